// File: rtl/fifo_packetizer_popcount.sv
`default_nettype none
// ---------------------------------------------------------------------------
// popcount : number of set bits in a valid vector
// Rev 1.0
// ---------------------------------------------------------------------------
module popcount #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  i_vec,
    output logic [CW-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int k = 0; k < N; k++) begin
            o_count = o_count + CW'(i_vec[k]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_packetizer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_packetizer : drains an upstream FIFO into length-prefixed packets
// Rev 1.0
// ---------------------------------------------------------------------------
module fifo_packetizer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int MAXLEN    = 8,
    parameter int THRESHOLD = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cg,
    input  logic             i_flush,
    input  logic             i_fifo_empty,
    input  logic [DEPTH-1:0] i_fifo_valid,
    input  logic [WIDTH-1:0] i_fifo_data,
    output logic             o_fifo_pop,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last,
    output logic             o_busy
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int RW  = $clog2(MAXLEN + 1);
    localparam int ICW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ICW-1:0] IDLE_LIMIT = ICW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e           state_q;
    logic [RW-1:0]    remain_q;
    logic [ICW-1:0]   idle_cnt_q;
    logic             valid_q;
    logic             last_q;
    logic [WIDTH-1:0] data_q;

    logic [CW-1:0]    w_count;
    logic [RW-1:0]    w_len;
    logic             w_load;
    logic             w_timeout_hit;
    logic             w_start;

    popcount #(
        .N  (DEPTH),
        .CW (CW)
    ) u_popcount (
        .i_vec   (i_fifo_valid),
        .o_count (w_count)
    );

    assign w_len         = (w_count > CW'(MAXLEN)) ? RW'(MAXLEN) : w_count[RW-1:0];
    assign w_timeout_hit = (TIMEOUT != 0) && (idle_cnt_q == IDLE_LIMIT);
    assign w_start       = (w_count >= CW'(THRESHOLD)) || ((w_count != '0) && w_timeout_hit);
    assign w_load        = i_cg && (!valid_q || i_ready);

    // The pop shares the edge that registers the head word into o_data.
    assign o_fifo_pop = (state_q == BODY) && w_load && !i_flush;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            data_q     <= '0;
            remain_q   <= '0;
            idle_cnt_q <= '0;
        end else if (i_flush) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            remain_q   <= '0;
            idle_cnt_q <= '0;
        end else if (i_cg) begin
            if (w_load) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (w_start) begin
                        remain_q   <= w_len;
                        idle_cnt_q <= '0;
                        state_q    <= HDR;
                    end else if (w_count == '0) begin
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q != IDLE_LIMIT) begin
                        idle_cnt_q <= idle_cnt_q + ICW'(1);
                    end
                end
                HDR: begin
                    if (w_load) begin
                        data_q  <= WIDTH'(remain_q);
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        state_q <= BODY;
                    end
                end
                BODY: begin
                    if (w_load) begin
                        data_q   <= i_fifo_data;
                        valid_q  <= 1'b1;
                        remain_q <= remain_q - RW'(1);
                        last_q   <= (remain_q == RW'(1));
                        if (remain_q == RW'(1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (valid_q && i_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_last  = last_q;
    assign o_busy  = (state_q != IDLE);

    // len never exceeds the buffered count, so a pop must find a word.
    a_pop_not_empty: assert property (@(posedge i_clk) disable iff (i_rst)
        o_fifo_pop |-> !i_fifo_empty);

endmodule
`default_nettype wire

// File: tb/tb_fifo_packetizer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_packetizer : self-checking bench for fifo_packetizer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fifo_packetizer;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 8;
    localparam int MAXLEN    = 5;
    localparam int THRESHOLD = 4;
    localparam int TIMEOUT   = 16;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             cg        = 1'b1;
    logic             flush     = 1'b0;
    logic             ready     = 1'b0;
    logic             push      = 1'b0;
    logic [WIDTH-1:0] push_word = '0;
    logic             fe        = 1'b1;
    logic [DEPTH-1:0] fv        = '0;
    logic [WIDTH-1:0] fd        = '0;
    logic             pop, ovalid, olast, obusy;
    logic [WIDTH-1:0] odata;

    int nvec  = 0;
    int nfail = 0;
    int pops  = 0;

    always #5 clk = ~clk;

    fifo_packetizer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .MAXLEN(MAXLEN),
        .THRESHOLD(THRESHOLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_flush(flush),
        .i_fifo_empty(fe), .i_fifo_valid(fv), .i_fifo_data(fd),
        .o_fifo_pop(pop), .o_valid(ovalid), .i_ready(ready),
        .o_data(odata), .o_last(olast), .o_busy(obusy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DEPTH-1:0] vmask(input int n);
        vmask = '0;
        for (int i = 0; i < n && i < DEPTH; i++) vmask[i] = 1'b1;
    endfunction

    // Upstream FIFO environment: pops on o_fifo_pop, flush clears it.
    logic [WIDTH-1:0] envq[$];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            envq.delete();
            fv <= '0; fd <= '0; fe <= 1'b1;
        end else begin
            if (flush) envq.delete();
            else begin
                if (pop) begin
                    if (envq.size() > 0) void'(envq.pop_front());
                    pops++;
                end
                if (push) envq.push_back(push_word);
            end
            fv <= vmask(envq.size());
            fd <= (envq.size() > 0) ? envq[0] : '0;
            fe <= (envq.size() == 0);
        end
    end

    // Reference model: packets are cut from the list of unclaimed words;
    // every accepted output word is compared against the expected stream.
    logic [WIDTH-1:0]   mq[$];
    logic [WIDTH:0]     expq[$];
    logic [WIDTH:0]     seen[$];
    logic [WIDTH:0]     want[$];
    bit                 busy       = 0;
    int                 waitc      = 0;
    int                 edge_no    = 0;
    int                 hdr_due    = -1;
    int                 hdr_len    = 0;
    bit                 stall_prev = 0;
    logic [WIDTH+1:0]   prev_out   = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete(); expq.delete();
            busy = 0; waitc = 0; hdr_due = -1; stall_prev = 0;
        end else begin : m_edge
            bit b0;
            int n;
            int len;
            edge_no++;
            if (hdr_due == edge_no) begin
                chk("hdr_timing", {ovalid, odata}, {1'b1, hdr_len[WIDTH-1:0]});
                hdr_due = -1;
            end
            if (stall_prev) chk("stall_hold", {ovalid, olast, odata}, prev_out);
            prev_out   = {ovalid, olast, odata};
            stall_prev = ovalid && !ready && !flush;
            if (flush) begin
                mq.delete(); expq.delete();
                busy = 0; waitc = 0; hdr_due = -1;
            end else begin
                if (cg) begin
                    b0 = busy;
                    if (ovalid && ready) begin
                        chk("sb_word_pending", expq.size() != 0, 1);
                        if (expq.size() != 0) begin
                            chk("sb_word", {olast, odata}, expq[0]);
                            if (expq[0][WIDTH]) busy = 0;
                            void'(expq.pop_front());
                        end
                        seen.push_back({olast, odata});
                    end
                    if (!b0) begin
                        n = mq.size();
                        if (n >= THRESHOLD || (n > 0 && TIMEOUT != 0 && waitc >= TIMEOUT - 1)) begin
                            len = (n < MAXLEN) ? n : MAXLEN;
                            expq.push_back({1'b0, len[WIDTH-1:0]});
                            for (int i = 0; i < len; i++) expq.push_back({(i == len - 1), mq.pop_front()});
                            busy = 1; waitc = 0;
                            hdr_due = edge_no + 2; hdr_len = len;
                        end else if (n == 0) waitc = 0;
                        else waitc++;
                    end
                end
                if (push) mq.push_back(push_word);
            end
        end
    end

    task automatic wait_quiet(input bit rnd, input int bound);
        int n = 0;
        bit quiet = 0;
        while (n < bound) begin
            quiet = (envq.size() == 0) && !obusy && !ovalid;
            if (quiet) break;
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            n++;
        end
        chk("quiet_in_time", quiet, 1);
        ready = 1'b1;
    endtask

    task automatic check_seen();
        chk("seen_len", seen.size(), want.size());
        for (int i = 0; i < seen.size() && i < want.size(); i++) chk("seen_word", seen[i], want[i]);
    endtask

    task automatic push_words(input logic [WIDTH-1:0] base, input int cnt, input bit rnd);
        for (int i = 0; i < cnt; i++) begin
            push = 1'b1; push_word = base + WIDTH'(i);
            if (rnd) ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        push = 1'b0;
    endtask

    typedef struct {
        logic push; logic [7:0] w; logic rdy;
        logic ev; logic [7:0] ed; logic el; logic ep;
    } vec_t;
    vec_t tbl [12];

    initial begin : main
        int p0;
        int off;
        tbl[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 8'h44, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_valid", ovalid, 0);
        chk("rst_last", olast, 0);
        chk("rst_data", odata, 0);
        chk("rst_busy", obusy, 0);
        chk("rst_pop", pop, 0);
        rst = 1'b0;
        ready = 1'b1;
        @(negedge clk);

        // Threshold packet, cycle by cycle
        p0 = pops;
        for (int i = 0; i < 12; i++) begin
            push = tbl[i].push; push_word = tbl[i].w; ready = tbl[i].rdy;
            @(negedge clk);
            chk("tbl_valid", ovalid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk("tbl_data", odata, tbl[i].ed);
                chk("tbl_last", olast, tbl[i].el);
            end
            chk("tbl_pop", pop, tbl[i].ep);
        end
        push = 1'b0;
        chk("tbl_pop_count", pops - p0, 4);

        // Timeout packet of two words
        seen.delete();
        push = 1'b1; push_word = 8'h5A; @(negedge clk);
        push_word = 8'hA5; @(negedge clk);
        push = 1'b0; off = 1;
        while (!ovalid && off < 40) begin @(negedge clk); off++; end
        chk("timeout_latency", off, 17);
        wait_quiet(0, 100);
        want = '{9'h002, 9'h05A, 9'h1A5};
        check_seen();

        // Eight words buffered while gated: MAXLEN packet then timeout remainder
        seen.delete(); p0 = pops; cg = 1'b0;
        push_words(8'h60, 8, 0);
        @(negedge clk);
        chk("cg_busy", obusy, 0);
        chk("cg_pop", pop, 0);
        cg = 1'b1;
        wait_quiet(0, 200);
        want = '{9'h005, 9'h060, 9'h061, 9'h062, 9'h063, 9'h164,
                 9'h003, 9'h065, 9'h066, 9'h167};
        check_seen();
        chk("maxlen_pops", pops - p0, 8);

        // Random backpressure over a four-word packet
        seen.delete(); p0 = pops;
        push_words(8'h71, 4, 1);
        wait_quiet(1, 200);
        want = '{9'h004, 9'h071, 9'h072, 9'h073, 9'h174};
        check_seen();
        chk("bp_pops", pops - p0, 4);

        // Flush after the second body word
        ready = 1'b1;
        push_words(8'h81, 4, 0);
        off = 0;
        while (!(ovalid && odata == 8'h82) && off < 30) begin @(negedge clk); off++; end
        chk("flush_reach", ovalid && odata == 8'h82, 1);
        flush = 1'b1;
        #1 chk("flush_pop", pop, 0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_valid", ovalid, 0);
        chk("flush_busy", obusy, 0);
        p0 = pops;
        repeat (5) @(negedge clk);
        chk("flush_no_pops", pops - p0, 0);
        chk("flush_valid_after", ovalid, 0);

        // Asynchronous reset mid-packet
        push_words(8'h91, 4, 0);
        off = 0;
        while (!(ovalid && odata == 8'h91) && off < 30) begin @(negedge clk); off++; end
        chk("rst_reach", ovalid && odata == 8'h91, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", ovalid, 0);
        chk("arst_last", olast, 0);
        chk("arst_data", odata, 0);
        chk("arst_busy", obusy, 0);
        chk("arst_pop", pop, 0);
        @(negedge clk);
        rst = 1'b0;
        seen.delete(); p0 = pops;
        push_words(8'hA1, 4, 0);
        wait_quiet(0, 100);
        want = '{9'h004, 9'h0A1, 9'h0A2, 9'h0A3, 9'h1A4};
        check_seen();
        chk("arst_pops", pops - p0, 4);

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            push = (envq.size() < DEPTH - 1) && ($urandom_range(0, 2) == 0);
            push_word = WIDTH'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        push = 1'b0;
        wait_quiet(1, 300);
        chk("sb_drained", expq.size(), 0);
        chk("model_fifo_empty", mq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
